bkm_iter_ctrl: RTL and testbench

//  Iteration sequencer and digit selector that sits directly upstream of bkm_step.

---
 rtl/bkm_iter_ctrl.sv | 116 +++++++++++
 tb/tb_bkm_iter_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/bkm_iter_ctrl.sv
// Iteration sequencer and digit selector feeding bkm_step: accepts one job, runs
// N iterations with on-the-fly digit selection, then holds the result until it is taken.
module bkm_iter_ctrl #(
  parameter int W     = 8,
  parameter int N     = 8,
  parameter int LOG2N = 3
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [1:0]       in_format,
  input  logic [W-1:0]     u_init,
  input  logic [W-1:0]     v_init,
  input  logic [W-1:0]     u_fb,
  input  logic [W-1:0]     v_fb,
  output logic             mode,
  output logic [1:0]       format,
  output logic [LOG2N-1:0] n,
  output logic [LOG2N-1:0] lut_addr,
  output logic [1:0]       d_x_n,
  output logic [1:0]       d_y_n,
  output logic             step_ena,
  output logic             step_init,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, DONE = 2'd2} state_t;

  localparam logic [LOG2N-1:0] N_LAST = LOG2N'(N - 1);

  state_t           state_q, state_d;
  logic [LOG2N-1:0] n_q, n_d;
  logic             mode_q;
  logic [1:0]       format_q;
  logic [W-1:0]     u_q, v_q;
  logic             accept;
  logic [3:0]       u_top, v_top;

  // Only the top nibble drives digit selection; the rest of the operands pass through bkm_step.
  logic unused_low_bits;
  assign unused_low_bits = ^{u_fb[W-5:0], v_fb[W-5:0], u_q[W-5:0], v_q[W-5:0]};

  function automatic logic [1:0] digit_sel(input logic signed [3:0] t);
    if (t >= 4'sd1)       digit_sel = 2'b01;
    else if (t <= -4'sd2) digit_sel = 2'b11;
    else                  digit_sel = 2'b00;
  endfunction

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (srst)        state_q <= IDLE;
    else if (enable) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = ITER;
      ITER:    if (n_q == N_LAST) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    n_d = n_q;
    if (state_q == IDLE && in_valid)            n_d = '0;
    else if (state_q == ITER && n_q != N_LAST)  n_d = n_q + LOG2N'(1);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      n_q      <= '0;
      mode_q   <= 1'b0;
      format_q <= 2'b00;
      u_q      <= '0;
      v_q      <= '0;
    end else if (enable) begin
      n_q <= n_d;
      if (accept) begin
        mode_q   <= in_mode;
        format_q <= in_format;
        u_q      <= u_init;
        v_q      <= v_init;
      end
    end
  end

  always_comb begin
    u_top     = (n_q == '0) ? u_q[W-1:W-4] : u_fb[W-1:W-4];
    v_top     = (n_q == '0) ? v_q[W-1:W-4] : v_fb[W-1:W-4];
    in_ready  = (state_q == IDLE) & enable;
    step_ena  = (state_q == ITER) & enable;
    step_init = (state_q == ITER) & (n_q == '0);
    busy      = (state_q != IDLE);
    out_valid = (state_q == DONE);
    d_x_n     = 2'b00;
    d_y_n     = 2'b00;
    if (state_q == ITER) begin
      d_x_n = digit_sel(u_top);
      d_y_n = digit_sel(v_top);
    end
  end

  assign mode     = mode_q;
  assign format   = format_q;
  assign n        = n_q;
  assign lut_addr = n_q;

endmodule

// File: tb/tb_bkm_iter_ctrl.sv
// Directed bench for bkm_iter_ctrl: reset, digit selection, enable stall,
// result back-pressure and mid-job reset, all against hand-computed values.
module tb_bkm_iter_ctrl;

  logic       clk = 1'b0;
  logic       srst, enable, in_valid, in_ready, in_mode;
  logic [1:0] in_format;
  logic [7:0] u_init, v_init, u_fb, v_fb;
  logic       mode;
  logic [1:0] format;
  logic [2:0] n, lut_addr;
  logic [1:0] d_x_n, d_y_n;
  logic       step_ena, step_init, busy, out_valid, out_ready;

  int tests_run = 0;
  int tests_failed = 0;
  int ena_cycles;

  always #5 clk = ~clk;

  bkm_iter_ctrl #(.W(8), .N(8), .LOG2N(3)) dut (
    .clk(clk), .srst(srst), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_format(in_format),
    .u_init(u_init), .v_init(v_init), .u_fb(u_fb), .v_fb(v_fb),
    .mode(mode), .format(format), .n(n), .lut_addr(lut_addr),
    .d_x_n(d_x_n), .d_y_n(d_y_n), .step_ena(step_ena), .step_init(step_init),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, exp);
    end else begin
      $display("[TB] ok   %s: %0h", tag, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    srst = 1'b1; enable = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_format = 2'b00;
    u_init = 8'h00; v_init = 8'h00; u_fb = 8'h00; v_fb = 8'h00; out_ready = 1'b0;

    // 1. reset
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_n", n, 0);
    check("rst_dx", d_x_n, 0);
    check("rst_dy", d_y_n, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_step_ena", step_ena, 0);
    srst = 1'b0;

    // 2. job accept and iteration-0 digits from latched init values
    in_valid = 1'b1; in_mode = 1'b1; in_format = 2'b10; u_init = 8'h40; v_init = 8'hE0;
    tick();
    in_valid = 1'b0; in_mode = 1'b0; in_format = 2'b00; u_init = 8'h00; v_init = 8'h00;
    check("it0_busy", busy, 1);
    check("it0_in_ready", in_ready, 0);
    check("it0_n", n, 0);
    check("it0_step_init", step_init, 1);
    check("it0_step_ena", step_ena, 1);
    check("it0_dx", d_x_n, 2'b01);
    check("it0_dy", d_y_n, 2'b11);
    check("it0_mode", mode, 1);
    check("it0_format", format, 2'b10);
    tick();
    check("it1_n", n, 1);
    check("it1_step_init", step_init, 0);
    check("it1_dx_fb0", d_x_n, 2'b00);
    tick(); tick();

    // 3. feedback digit selection at n=3
    check("it3_n", n, 3);
    check("it3_lut_addr", lut_addr, 3);
    u_fb = 8'hF0; v_fb = 8'h10; #1;
    check("it3_dx_F0", d_x_n, 2'b00);
    check("it3_dy_10", d_y_n, 2'b01);
    u_fb = 8'h80; #1;
    check("it3_dx_80", d_x_n, 2'b11);
    u_fb = 8'h00; v_fb = 8'h00;
    tick();

    // 4. enable stall at n=4
    check("it4_n", n, 4);
    enable = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      check("stall_step_ena", step_ena, 0);
      check("stall_in_ready", in_ready, 0);
      tick();
      check("stall_n", n, 4);
    end
    enable = 1'b1; #1;
    check("resume_step_ena", step_ena, 1);
    check("resume_n", n, 4);
    tick(); tick(); tick();
    check("it7_n", n, 7);
    check("it7_out_valid", out_valid, 0);
    tick();
    check("done_out_valid", out_valid, 1);
    check("done_step_ena", step_ena, 0);
    check("done_n", n, 7);

    // 5. back-pressure in DONE, including a stalled edge
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1; enable = 1'b0;
    tick();
    check("hold_disabled_out_valid", out_valid, 1);
    enable = 1'b1;
    tick();
    out_ready = 1'b0;
    check("handoff_busy", busy, 0);
    check("handoff_out_valid", out_valid, 0);
    check("handoff_in_ready", in_ready, 1);

    // 6. srst mid-job, then a clean job with cycle count
    in_valid = 1'b1; in_mode = 1'b1; in_format = 2'b01; u_init = 8'h10; v_init = 8'h00;
    tick();
    in_valid = 1'b0;
    check("j2_dx", d_x_n, 2'b01);
    check("j2_dy", d_y_n, 2'b00);
    for (int i = 0; i < 5; i++) tick();
    check("j2_n5", n, 5);
    srst = 1'b1; enable = 1'b0;
    tick();
    srst = 1'b0; enable = 1'b1; #1;
    check("srst_busy", busy, 0);
    check("srst_n", n, 0);
    check("srst_out_valid", out_valid, 0);
    check("srst_mode", mode, 0);
    check("srst_format", format, 0);
    check("srst_in_ready", in_ready, 1);

    in_valid = 1'b1; in_mode = 1'b0; in_format = 2'b11; u_init = 8'hD0; v_init = 8'h70;
    tick();
    in_valid = 1'b0;
    check("j3_dx", d_x_n, 2'b11);
    check("j3_dy", d_y_n, 2'b01);
    check("j3_format", format, 2'b11);
    ena_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) break;
      if (step_ena) ena_cycles++;
      tick();
    end
    check("j3_out_valid", out_valid, 1);
    check("j3_iter_cycles", ena_cycles, 8);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("j3_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
